// File: rtl/transmit_stream.sv
// transmit_stream: packetising UART transmitter.
// Collects 256 payload bytes into a block RAM and sends them as a single
// SoP/EoP-framed packet. It then waits for a one-byte acknowledgement and
// retransmits on NAK or timeout, up to MAX_RETRIES times, before the packet
// is dropped.
module transmit_stream #(
  parameter logic [7:0]  SOURCE      = 8'h10,
  parameter logic [7:0]  DESTINATION = 8'hAA,
  parameter int unsigned TIMEOUT     = 2_500_000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic       ipClk,
  input  logic       ipReset,

  input  logic [7:0] ipData,
  input  logic       ipValid,
  output logic       opReady,

  output logic [7:0] opTxSource,
  output logic [7:0] opTxDestination,
  output logic [7:0] opTxLength,
  output logic       opTxSoP,
  output logic       opTxEoP,
  output logic [7:0] opTxData,
  output logic       opTxValid,
  input  logic       ipTxReady,

  input  logic [7:0] ipRxSource,
  input  logic [7:0] ipRxDestination,
  input  logic [7:0] ipRxLength,
  input  logic       ipRxSoP,
  input  logic       ipRxEoP,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,

  output logic       opBusy,
  output logic [1:0] opRetries,
  output logic       opError
);

  localparam logic [1:0] FILL     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [7:0]  wrIndex;
  logic [7:0]  rdIndex;
  logic [7:0]  rdAddr;
  logic [7:0]  ramQ;
  logic [31:0] timer;
  logic [7:0]  mem [0:255];

  logic fillAccept;
  logic txAccept;
  logic ackValid;
  logic ackGood;
  logic ackFail;
  logic canRetry;

  // The ack length field carries no information for a one-byte ack.
  logic unusedRxLength;
  assign unusedRxLength = ^ipRxLength;

  assign opReady    = (state == FILL);
  assign fillAccept = ipValid && opReady;
  assign txAccept   = opTxValid && ipTxReady;

  // An ack is a single-byte packet addressed back to us from our peer.
  assign ackValid = (state == WAIT_ACK) && ipRxValid && ipRxSoP && ipRxEoP &&
                    (ipRxSource == DESTINATION) && (ipRxDestination == SOURCE);
  assign ackGood  = ackValid && (ipRxData == 8'h00);
  // A good ack in the same cycle as the timeout takes priority.
  assign ackFail  = (state == WAIT_ACK) && !ackGood &&
                    ((ackValid && (ipRxData != 8'h00)) || (timer == TIMEOUT_LAST));
  assign canRetry = (opRetries < RETRY_LIMIT);

  // Read address runs one byte ahead of the presented byte, two ahead when
  // the presented byte is being taken, so back-to-back bytes never stall.
  always_comb begin
    rdAddr = 8'd0;
    if (state == SEND) begin
      if (!opTxValid) begin
        rdAddr = 8'd1;
      end else if (ipTxReady) begin
        rdAddr = rdIndex + 8'd2;
      end else begin
        rdAddr = rdIndex + 8'd1;
      end
    end
  end

  // Next-state decode for the fill / send / wait-for-ack sequence.
  always_comb begin
    stateNext = state;
    case (state)
      FILL:     if (fillAccept && (wrIndex == 8'hFF)) stateNext = SEND;
      SEND:     if (txAccept && opTxEoP) stateNext = WAIT_ACK;
      WAIT_ACK: begin
        if (ackGood) begin
          stateNext = FILL;
        end else if (ackFail) begin
          stateNext = canRetry ? SEND : FILL;
        end
      end
      default:  stateNext = FILL;
    endcase
  end

  // Packet buffer: write during fill, registered read for block RAM mapping.
  always_ff @(posedge ipClk) begin
    if (fillAccept) begin
      mem[wrIndex] <= ipData;
    end
    ramQ <= mem[rdAddr];
  end

  // State, fill index, ack timer, retry count and sticky error flag.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state     <= FILL;
      opBusy    <= 1'b0;
      wrIndex   <= 8'd0;
      timer     <= 32'd0;
      opRetries <= 2'd0;
      opError   <= 1'b0;
    end else begin
      state  <= stateNext;
      opBusy <= (stateNext != FILL);
      if (fillAccept) begin
        wrIndex <= wrIndex + 8'd1;
      end
      if (txAccept && opTxEoP) begin
        timer <= 32'd0;
      end else if (state == WAIT_ACK) begin
        timer <= timer + 32'd1;
      end
      if (ackGood) begin
        opRetries <= 2'd0;
      end else if (ackFail) begin
        if (canRetry) begin
          opRetries <= opRetries + 2'd1;
        end else begin
          opRetries <= 2'd0;
          opError   <= 1'b1;
        end
      end
    end
  end

  // Outgoing stream register: the first SEND cycle primes byte 0, then each
  // accepted byte is replaced by the prefetched one; fields hold otherwise.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      opTxSource      <= 8'd0;
      opTxDestination <= 8'd0;
      opTxLength      <= 8'd0;
      opTxSoP         <= 1'b0;
      opTxEoP         <= 1'b0;
      opTxData        <= 8'd0;
      opTxValid       <= 1'b0;
      rdIndex         <= 8'd0;
    end else if (state == SEND) begin
      if (!opTxValid) begin
        opTxSource      <= SOURCE;
        opTxDestination <= DESTINATION;
        opTxLength      <= 8'h00;
        opTxData        <= ramQ;
        opTxSoP         <= 1'b1;
        opTxEoP         <= 1'b0;
        opTxValid       <= 1'b1;
        rdIndex         <= 8'd0;
      end else if (ipTxReady) begin
        if (opTxEoP) begin
          opTxValid <= 1'b0;
          opTxSoP   <= 1'b0;
          opTxEoP   <= 1'b0;
        end else begin
          rdIndex  <= rdIndex + 8'd1;
          opTxData <= ramQ;
          opTxSoP  <= 1'b0;
          opTxEoP  <= (rdIndex == 8'hFE);
        end
      end
    end
  end

endmodule

// File: tb/tb_transmit_stream.sv
// Testbench for transmit_stream: random payloads checked against a stored
// copy of each packet, plus ack handling, retries, backpressure and reset.
module tb_transmit_stream;

  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] SRC     = 8'h10;
  localparam logic [7:0] DST     = 8'hAA;

  logic       ipClk;
  logic       ipReset;
  logic [7:0] ipData;
  logic       ipValid;
  logic       opReady;
  logic [7:0] opTxSource;
  logic [7:0] opTxDestination;
  logic [7:0] opTxLength;
  logic       opTxSoP;
  logic       opTxEoP;
  logic [7:0] opTxData;
  logic       opTxValid;
  logic       ipTxReady;
  logic [7:0] ipRxSource;
  logic [7:0] ipRxDestination;
  logic [7:0] ipRxLength;
  logic       ipRxSoP;
  logic       ipRxEoP;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  logic       opBusy;
  logic [1:0] opRetries;
  logic       opError;

  transmit_stream #(
    .SOURCE(SRC), .DESTINATION(DST), .TIMEOUT(TIMEOUT), .MAX_RETRIES(3)
  ) dut (
    .ipClk(ipClk), .ipReset(ipReset),
    .ipData(ipData), .ipValid(ipValid), .opReady(opReady),
    .opTxSource(opTxSource), .opTxDestination(opTxDestination),
    .opTxLength(opTxLength), .opTxSoP(opTxSoP), .opTxEoP(opTxEoP),
    .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
    .ipRxSource(ipRxSource), .ipRxDestination(ipRxDestination),
    .ipRxLength(ipRxLength), .ipRxSoP(ipRxSoP), .ipRxEoP(ipRxEoP),
    .ipRxData(ipRxData), .ipRxValid(ipRxValid),
    .opBusy(opBusy), .opRetries(opRetries), .opError(opError)
  );

  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  int cycle = 0;
  always @(posedge ipClk) cycle <= cycle + 1;

  // Monitor: records every accepted output byte and flags any field change
  // while a valid byte is being held back.
  logic [7:0]  capData [$];
  logic        capSoP [$];
  logic        capEoP [$];
  logic [23:0] capHdr [$];
  int          capCycle [$];
  int          stableErr = 0;
  logic        prevHeld = 1'b0;
  logic [34:0] prevFields = '0;

  always @(negedge ipClk) begin
    if (ipReset) begin
      prevHeld = 1'b0;
    end else begin
      if (prevHeld && ({opTxSource, opTxDestination, opTxLength, opTxSoP, opTxEoP,
                        opTxData, opTxValid} !== prevFields)) begin
        stableErr++;
      end
      if (opTxValid && ipTxReady) begin
        capData.push_back(opTxData);
        capSoP.push_back(opTxSoP);
        capEoP.push_back(opTxEoP);
        capHdr.push_back({opTxDestination, opTxSource, opTxLength});
        capCycle.push_back(cycle);
      end
      prevHeld   = opTxValid && !ipTxReady;
      prevFields = {opTxSource, opTxDestination, opTxLength, opTxSoP, opTxEoP,
                    opTxData, opTxValid};
    end
  end

  int         checks = 0;
  int         failures = 0;
  logic [7:0] expPkt [256];
  int         capBase = 0;
  int         stableBase = 0;
  int         fillDone = 0;
  int         ackCycle = 0;
  int         eopCycle = 0;

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int capCount();
    return capData.size() - capBase;
  endfunction

  task automatic clearCap();
    capBase = capData.size();
  endtask

  // New random payload, fed with optional idle gaps.
  task automatic fillPacket(input string tag, input bit gaps);
    check({tag, "_ready_at_start"}, opReady, 1);
    for (int i = 0; i < 256; i++) expPkt[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        ipValid = 1'b0;
        tick();
      end
      ipData  = expPkt[i];
      ipValid = 1'b1;
      tick();
    end
    ipValid  = 1'b0;
    fillDone = cycle;
    check({tag, "_ready_drop"}, opReady, 0);
    check({tag, "_busy"}, opBusy, 1);
  endtask

  task automatic waitPacket(input string tag, input bit randReady);
    int n = 0;
    while ((capCount() < 256) && (n < 3000)) begin
      ipTxReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    ipTxReady = 1'b1;
    check({tag, "_complete"}, capCount() >= 256, 1);
  endtask

  // Captured packet must equal the stored payload with the fixed header and
  // SoP/EoP framing on the first/last byte only.
  task automatic checkPacket(input string tag);
    int dErr = 0;
    int fErr = 0;
    int hErr = 0;
    check({tag, "_len"}, capCount(), 256);
    for (int i = 0; (i < 256) && (i < capCount()); i++) begin
      int k = capBase + i;
      if (capData[k] !== expPkt[i]) dErr++;
      if (capSoP[k] !== (i == 0)) fErr++;
      if (capEoP[k] !== (i == 255)) fErr++;
      if (capHdr[k] !== {DST, SRC, 8'h00}) hErr++;
    end
    check({tag, "_data_errs"}, dErr, 0);
    check({tag, "_frame_errs"}, fErr, 0);
    check({tag, "_hdr_errs"}, hErr, 0);
    $display("packet %s: bytes=%0d data_errs=%0d frame_errs=%0d hdr_errs=%0d",
             tag, capCount(), dErr, fErr, hErr);
  endtask

  task automatic sendAck(input logic [7:0] src, input logic [7:0] dst,
                         input logic sop, input logic eop, input logic [7:0] data);
    ipRxSource      = src;
    ipRxDestination = dst;
    ipRxLength      = 8'h01;
    ipRxSoP         = sop;
    ipRxEoP         = eop;
    ipRxData        = data;
    ipRxValid       = 1'b1;
    tick();
    ipRxValid = 1'b0;
    ackCycle  = cycle;
    $display("ack src=%0h dst=%0h sop=%0b eop=%0b data=%0h ready=%0b retries=%0d",
             src, dst, sop, eop, data, opReady, opRetries);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_tx_fields"}, {opTxSource, opTxDestination, opTxLength, opTxData}, 0);
    check({tag, "_tx_flags"}, {opTxSoP, opTxEoP, opTxValid}, 0);
    check({tag, "_ready"}, opReady, 1);
    check({tag, "_busy"}, opBusy, 0);
    check({tag, "_retries"}, opRetries, 0);
    check({tag, "_error"}, opError, 0);
  endtask

  initial begin
    int n;
    int lat;
    ipReset = 1'b1; ipData = 8'h00; ipValid = 1'b0; ipTxReady = 1'b1;
    ipRxSource = 8'h00; ipRxDestination = 8'h00; ipRxLength = 8'h00;
    ipRxSoP = 1'b0; ipRxEoP = 1'b0; ipRxData = 8'h00; ipRxValid = 1'b0;

    // Reset state
    repeat (3) tick();
    checkResetOutputs("reset");
    ipReset = 1'b0;
    tick();

    // Normal delivery, ack 00 at 100 cycles after EoP
    clearCap();
    fillPacket("normal", 1'b1);
    waitPacket("normal", 1'b0);
    checkPacket("normal");
    if (capCount() >= 256) begin
      lat = capCycle[capBase] - fillDone;
      check("normal_fill_latency", (lat >= 0) && (lat <= 2), 1);
      check("normal_stream_span", capCycle[capBase + 255] - capCycle[capBase], 255);
    end
    check("normal_valid_after_eop", opTxValid, 0);
    repeat (99) tick();
    check("normal_wait_busy", opBusy, 1);
    check("normal_wait_ready", opReady, 0);
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h00);
    check("normal_ready_after_ack", opReady, 1);
    check("normal_retries_after_ack", opRetries, 0);

    // NAK then retransmission then good ack
    clearCap();
    fillPacket("nak", 1'b0);
    waitPacket("nak", 1'b0);
    checkPacket("nak");
    repeat (50) tick();
    clearCap();
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h04);
    check("nak_retries", opRetries, 1);
    check("nak_ready", opReady, 0);
    waitPacket("nak_retx", 1'b0);
    checkPacket("nak_retx");
    if (capCount() >= 256) begin
      lat = capCycle[capBase] - ackCycle;
      check("nak_retx_latency", (lat >= 0) && (lat <= 2), 1);
    end
    repeat (20) tick();
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h00);
    check("nak_ready_after_ack", opReady, 1);
    check("nak_retries_after_ack", opRetries, 0);

    // Filtering of foreign and malformed acks
    clearCap();
    fillPacket("filter", 1'b0);
    waitPacket("filter", 1'b0);
    checkPacket("filter");
    clearCap();
    sendAck(8'h55, SRC, 1'b1, 1'b1, 8'h00);
    check("filter_wrong_src", opReady, 0);
    sendAck(DST, SRC, 1'b1, 1'b0, 8'h00);
    sendAck(DST, SRC, 1'b0, 1'b1, 8'h00);
    check("filter_two_byte", opReady, 0);
    sendAck(DST, 8'h33, 1'b1, 1'b1, 8'h04);
    check("filter_wrong_dst_ready", opReady, 0);
    check("filter_wrong_dst_retries", opRetries, 0);
    check("filter_no_retx", capCount(), 0);
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h00);
    check("filter_good_ack", opReady, 1);

    // Ack outside WAIT_ACK is ignored; then backpressure at 50%
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h04);
    check("idle_ack_retries", opRetries, 0);
    check("idle_ack_ready", opReady, 1);
    clearCap();
    stableBase = stableErr;
    fillPacket("bp", 1'b1);
    waitPacket("bp", 1'b1);
    checkPacket("bp");
    check("bp_hold_stable", stableErr - stableBase, 0);
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h00);
    check("bp_ready_after_ack", opReady, 1);
    check("bp_error_clear", opError, 0);

    // Silent far end: three timed retransmissions, then give up
    clearCap();
    fillPacket("to", 1'b0);
    waitPacket("to", 1'b0);
    checkPacket("to");
    eopCycle = (capCount() >= 256) ? capCycle[capBase + 255] : cycle;
    for (int r = 1; r <= 3; r++) begin
      clearCap();
      waitPacket($sformatf("to_retx%0d", r), 1'b0);
      check($sformatf("to_retries%0d", r), opRetries, r);
      checkPacket($sformatf("to_retx%0d", r));
      if (capCount() >= 256) begin
        lat = capCycle[capBase] - eopCycle;
        check($sformatf("to_gap%0d", r), (lat >= TIMEOUT) && (lat <= TIMEOUT + 3), 1);
        eopCycle = capCycle[capBase + 255];
      end
    end
    clearCap();
    n = 0;
    while (!opReady && (n < 1200)) begin
      tick();
      n++;
    end
    check("to_giveup_reached", opReady, 1);
    lat = cycle - eopCycle;
    check("to_giveup_gap", (lat >= TIMEOUT) && (lat <= TIMEOUT + 3), 1);
    check("to_error_set", opError, 1);
    check("to_retries_clear", opRetries, 0);
    check("to_no_fifth_send", capCount(), 0);
    $display("giveup after %0d cycles error=%0b", lat, opError);

    // Reset in the middle of a packet
    clearCap();
    fillPacket("rst", 1'b0);
    n = 0;
    while ((capCount() < 77) && (n < 1000)) begin
      tick();
      n++;
    end
    check("rst_reached_byte77", capCount() >= 77, 1);
    #2;
    ipReset = 1'b1;
    #1;
    checkResetOutputs("midsend_reset");
    repeat (2) tick();
    ipReset = 1'b0;
    tick();
    clearCap();
    fillPacket("after_rst", 1'b1);
    waitPacket("after_rst", 1'b0);
    checkPacket("after_rst");
    sendAck(DST, SRC, 1'b1, 1'b1, 8'h00);
    check("after_rst_ready", opReady, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transmit_stream.md
# transmit_stream

Packetising transmitter that pairs with the receive-side stream block over the UART packet link. It collects a byte stream into a 256-byte packet buffer and sends it as one UART_PACKET with SoP/EoP framing. It then waits for a one-byte acknowledgement from the far end and retransmits on NAK or timeout. It sits between the on-chip data source and the UART packet transmitter, and also taps the UART packet receiver for acknowledgements.

## Interface
- SOURCE, 8'h10: value driven on opTxStream.Source; expected in ipRxStream.Destination of acks.
- DESTINATION, 8'hAA: value driven on opTxStream.Destination; expected in ipRxStream.Source of acks.
- TIMEOUT, 2_500_000: ack wait in clock cycles (50 ms at 50 MHz), counted from EoP acceptance.
- MAX_RETRIES, 3: retransmissions allowed per packet before the packet is dropped.

- ipClk  input  1  system clock; all logic on rising edge.
- ipReset  input  1  asynchronous, active-high reset.
- ipData  input  8  payload byte.
- ipValid  input  1  ipData is valid.
- opReady  output  1  block accepts a byte; a transfer happens when ipValid && opReady.
- opTxStream  output  UART_PACKET  outgoing packet stream (Source, Destination, Length, SoP, EoP, Data, Valid).
- ipTxReady  input  1  downstream accepts the byte on opTxStream this cycle.
- ipRxStream  input  UART_PACKET  incoming packet stream carrying acks; one-cycle Valid strobes.
- opBusy  output  1  high in SEND or WAIT_ACK.
- opRetries  output  2  retransmissions issued for the current packet.
- opError  output  1  sticky; set when a packet is dropped after MAX_RETRIES.

## Operation
- Buffer: 256x8 RAM with registered (1-cycle) read, plus an 8-bit write index and an 8-bit read index.
- FILL (reset state): opReady=1. Each accepted byte is written at the write index, and the index increments (wraps to 0 at 256). When the 256th byte is accepted, go to SEND next cycle; opReady drops in that same next cycle.
- SEND: opReady=0. Outputs are Destination=DESTINATION, Source=SOURCE, Length=8'h00 (256-byte packet), Data=buf[n], SoP=(n==0), EoP=(n==255).
  - Valid is held with stable fields until ipTxReady. Byte n+1 is presented the cycle after byte n is accepted, which requires read prefetch.
  - After EoP is accepted: Valid=0, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK: opReady=0. The timeout counter increments each cycle. A valid ack is an ipRxStream.Valid strobe with SoP=1, EoP=1, Source=DESTINATION and Destination=SOURCE. Bytes that fail any of these checks are ignored.
  - Ack Data==8'h00: packet delivered. Clear opRetries, go to FILL.
  - Ack Data!=8'h00 (8'h04 means the receiver timed out), or counter reaches TIMEOUT-1: this is a failure.
    - If opRetries<MAX_RETRIES: increment opRetries and go to SEND from byte 0. The buffer content is unchanged.
    - Otherwise: set opError, clear opRetries, go to FILL. The packet is discarded.
  - If an ack and the timeout arrive in the same cycle, the ack wins.
- ipRxStream is ignored outside WAIT_ACK.
- opTxStream.Valid never asserts outside SEND.

## Timing
- Reset values:
  - State FILL, opReady=1.
  - opTxStream all fields 0 (Valid=0).
  - opBusy=0, opRetries=0, opError=0, both indexes 0, timeout counter 0.
- Reset asserted mid-SEND drops Valid immediately (asynchronously). The partial packet and buffer content are lost, and operation restarts in FILL.
- Fill to first byte: SoP with Valid appears no later than 2 cycles after the 256th input byte is accepted.
- Streaming: with ipTxReady held high, one byte is sent per cycle, so the packet occupies 256 consecutive cycles.
- Backpressure: when ipTxReady is low, all opTxStream fields hold their values exactly.
- Ack to next state: the state changes the cycle after the ack strobe. For a retransmission, SoP is presented no later than 2 cycles after the strobe.
- Timeout: retransmission starts TIMEOUT cycles (±1) after EoP acceptance.
- opBusy is registered and follows the state register.
- opError is cleared only by reset.

## Test plan
- Normal: feed bytes 0..255 at 1 per cycle, ipTxReady=1, and ack Data=00 at 100 cycles after EoP. Expect:
  - one packet with Dest=AA, Src=10, Len=00 and Data 0..255 in order;
  - SoP only on byte 0 and EoP only on byte 255;
  - opReady high again 1 cycle after the ack, opRetries=0.
- NAK: same as normal but ack Data=04. Expect an identical packet retransmitted with opRetries=1; then ack 00 gives FILL with opRetries=0.
- Timeout and give-up: TIMEOUT=1000 and no ack. Expect:
  - retransmissions at roughly 1000-cycle spacing, opRetries counting 1,2,3;
  - after the fourth silent wait, opError=1 and return to FILL.
- Filtering: in WAIT_ACK, send an ack from Src=55 with Data=00, then a 2-byte packet from the right source. Both are ignored. A correct ack then completes the packet.
- Backpressure: toggle ipTxReady randomly at 50%. Expect the received packet byte-identical to the input, with fields stable while ipTxReady=0.
- Reset mid-operation: assert ipReset at byte 77 of SEND. Expect Valid=0 at once and all outputs at reset values. After release, a fresh 256-byte fill sends the new data correctly.
